// File: rtl/vdp_super_vram_arbiter.sv
// Slot arbiter for the 32-bit super-res VRAM word port: display, refresh, CPU and command engine share fixed 4-cycle slots.
// Define VDP_SUPER_ARB_FAIRNESS_EN to let a waiting command engine pre-empt the CPU after FAIR_LIMIT grants.
//
// owner        | meaning
// OWN_IDLE     | no access this slot
// OWN_DISP     | display fetch read, data lands in vrm_32
// OWN_REFRESH  | one-cycle refresh strobe, no ack
// OWN_CPU      | CPU read or write, ack at phase 3
// OWN_CMD      | command engine read or write, ack at phase 3
module vdp_super_vram_arbiter #(
    parameter int REFRESH_CX = 723,
    parameter int FAIR_LIMIT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  cx,
    input  logic        vdp_super,
    input  logic        super_res_drawing,
    input  logic [16:0] super_res_vram_addr,
    output logic [31:0] vrm_32,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        cmd_req,
    input  logic        cmd_we,
    input  logic [16:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        cmd_ack,
    output logic [31:0] cmd_rdata,
    output logic [16:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_refresh,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  slot_owner
);

    typedef enum logic [2:0] {
        OWN_IDLE,
        OWN_DISP,
        OWN_REFRESH,
        OWN_CPU,
        OWN_CMD
    } owner_t;

    localparam logic [9:0] REFRESH_CX_W = REFRESH_CX[9:0];

    owner_t owner;
    owner_t winner;
    logic   refresh_pend;
    logic   slot_we;
    logic   cmd_first;

`ifdef VDP_SUPER_ARB_FAIRNESS_EN
    localparam logic [1:0] FAIR_LIMIT_W = FAIR_LIMIT[1:0];
    logic [1:0] fair_cnt;

    assign cmd_first = cmd_req && (fair_cnt >= FAIR_LIMIT_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fair_cnt <= 2'd0;
        end else if (cx[1:0] == 2'd0) begin
            if (winner == OWN_CPU) begin
                if (!cmd_req)
                    fair_cnt <= 2'd0;
                else if (fair_cnt != 2'd3)
                    fair_cnt <= fair_cnt + 2'd1;
            end else if (winner == OWN_CMD) begin
                fair_cnt <= 2'd0;
            end
        end
    end
`else
    logic fair_limit_unused;
    assign fair_limit_unused = ^FAIR_LIMIT[1:0];
    assign cmd_first = 1'b0;
`endif

    always_comb begin
        winner = OWN_IDLE;
        if (vdp_super && super_res_drawing)
            winner = OWN_DISP;
        else if (refresh_pend)
            winner = OWN_REFRESH;
        else if (cpu_req && !cmd_first)
            winner = OWN_CPU;
        else if (cmd_req)
            winner = OWN_CMD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner        <= OWN_IDLE;
            slot_owner   <= 2'd0;
            slot_we      <= 1'b0;
            refresh_pend <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_refresh  <= 1'b0;
            vrm_32       <= '0;
            cpu_rdata    <= '0;
            cmd_rdata    <= '0;
            cpu_ack      <= 1'b0;
            cmd_ack      <= 1'b0;
        end else begin
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_refresh <= 1'b0;
            cpu_ack     <= 1'b0;
            cmd_ack     <= 1'b0;

            // A new pending edge beats a same-cycle refresh grant.
            if (cx == REFRESH_CX_W)
                refresh_pend <= 1'b1;
            else if (cx[1:0] == 2'd0 && winner == OWN_REFRESH)
                refresh_pend <= 1'b0;

            case (cx[1:0])
                2'd0: begin
                    owner <= winner;
                    case (winner)
                        OWN_DISP: begin
                            slot_owner <= 2'd1;
                            slot_we    <= 1'b0;
                            mem_rd     <= 1'b1;
                            mem_addr   <= super_res_vram_addr;
                            mem_be     <= 4'hF;
                        end
                        OWN_REFRESH: begin
                            slot_owner  <= 2'd3;
                            mem_refresh <= 1'b1;
                        end
                        OWN_CPU: begin
                            slot_owner <= 2'd2;
                            slot_we    <= cpu_we;
                            mem_rd     <= !cpu_we;
                            mem_wr     <= cpu_we;
                            mem_addr   <= cpu_addr;
                            mem_wdata  <= cpu_wdata;
                            mem_be     <= cpu_be;
                        end
                        OWN_CMD: begin
                            slot_owner <= 2'd3;
                            slot_we    <= cmd_we;
                            mem_rd     <= !cmd_we;
                            mem_wr     <= cmd_we;
                            mem_addr   <= cmd_addr;
                            mem_wdata  <= cmd_wdata;
                            mem_be     <= cmd_be;
                        end
                        default: slot_owner <= 2'd0;
                    endcase
                end
                2'd2: begin
                    if (owner == OWN_DISP)
                        vrm_32 <= mem_rdata;
                    if (owner == OWN_CPU && !slot_we)
                        cpu_rdata <= mem_rdata;
                    if (owner == OWN_CMD && !slot_we)
                        cmd_rdata <= mem_rdata;
                end
                2'd3: begin
                    cpu_ack <= (owner == OWN_CPU);
                    cmd_ack <= (owner == OWN_CMD);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// Directed bench for vdp_super_vram_arbiter; the bench drives cx and models VRAM with byte-enable writes.
module tb_vdp_super_vram_arbiter;

    logic        clk;
    logic        reset_n;
    logic [9:0]  cx;
    logic        vdp_super;
    logic        super_res_drawing;
    logic [16:0] super_res_vram_addr;
    logic [31:0] vrm_32;
    logic        cpu_req, cpu_we;
    logic [16:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cmd_req, cmd_we;
    logic [16:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;
    logic        cmd_ack;
    logic [31:0] cmd_rdata;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rd, mem_wr, mem_refresh;
    logic [31:0] mem_rdata;
    logic [1:0]  slot_owner;

    int vectors = 0;
    int miscompares = 0;

    vdp_super_vram_arbiter dut (
        .clk(clk), .reset_n(reset_n), .cx(cx),
        .vdp_super(vdp_super), .super_res_drawing(super_res_drawing),
        .super_res_vram_addr(super_res_vram_addr), .vrm_32(vrm_32),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_be(cmd_be), .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh),
        .mem_rdata(mem_rdata), .slot_owner(slot_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: unwritten words read as 0x5A000000 | addr.
    logic [31:0] vram_wr [logic [16:0]];

    function automatic logic [31:0] model_word(input logic [16:0] a);
        if (vram_wr.exists(a))
            return vram_wr[a];
        return 32'h5A00_0000 | {15'd0, a};
    endfunction

    always @(negedge clk) begin : vram_blk
        logic [31:0] w;
        if (mem_wr) begin
            w = model_word(mem_addr);
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            vram_wr[mem_addr] = w;
        end
        mem_rdata = model_word(mem_addr);
    end

    // One clock: outputs of the edge are visible afterwards, and cx advances for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        cx = cx + 10'd1;
    endtask

    task automatic test_reset();
        vectors++; if (slot_owner !== 2'd0) begin miscompares++; $display("FAIL reset_owner got %0d want 0", slot_owner); end
        vectors++; if ({mem_rd, mem_wr, mem_refresh} !== 3'b000) begin miscompares++; $display("FAIL reset_cmds got %b want 000", {mem_rd, mem_wr, mem_refresh}); end
        vectors++; if ({cpu_ack, cmd_ack} !== 2'b00) begin miscompares++; $display("FAIL reset_acks got %b want 00", {cpu_ack, cmd_ack}); end
        vectors++; if (mem_addr !== 17'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0) begin miscompares++; $display("FAIL reset_bus got %h/%h/%h want 0", mem_addr, mem_wdata, mem_be); end
        vectors++; if (vrm_32 !== 32'd0 || cpu_rdata !== 32'd0 || cmd_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_data got %h/%h/%h want 0", vrm_32, cpu_rdata, cmd_rdata); end
    endtask

    task automatic test_display();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h5A00_0000; exp_w[1] = 32'h5A00_0001; exp_w[2] = 32'h5A00_0002;
        cx = 10'd0;
        vdp_super = 1'b1; super_res_drawing = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00005;
        for (int i = 0; i < 3; i++) begin
            super_res_vram_addr = 17'(i);
            step();
            vectors++; if (mem_rd !== 1'b1 || mem_addr !== 17'(i)) begin miscompares++; $display("FAIL disp_rd[%0d] got rd=%b addr=%h want rd=1 addr=%h", i, mem_rd, mem_addr, i); end
            vectors++; if (slot_owner !== 2'd1) begin miscompares++; $display("FAIL disp_owner[%0d] got %0d want 1", i, slot_owner); end
            step();
            vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL disp_rd_width[%0d] got %b want 0", i, mem_rd); end
            step();
            step();
            vectors++; if (vrm_32 !== exp_w[i]) begin miscompares++; $display("FAIL disp_vrm[%0d] got %h want %h", i, vrm_32, exp_w[i]); end
            vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL disp_cpu_starved[%0d] got ack=%b want 0", i, cpu_ack); end
        end
        super_res_drawing = 1'b0; cpu_req = 1'b0;
        step();
        vectors++; if (slot_owner !== 2'd0 || mem_rd !== 1'b0) begin miscompares++; $display("FAIL idle_slot got owner=%0d rd=%b want 0/0", slot_owner, mem_rd); end
        vectors++; if (vrm_32 !== 32'h5A00_0002) begin miscompares++; $display("FAIL vrm_hold got %h want 5a000002", vrm_32); end
        step(); step(); step();
    endtask

    task automatic test_refresh();
        vdp_super = 1'b1; super_res_drawing = 1'b0;
        cx = 10'd716;
        for (int k = 0; k < 8; k++) step();
        vectors++; if (mem_refresh !== 1'b0) begin miscompares++; $display("FAIL refresh_early got %b want 0", mem_refresh); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00123;
        step();
        vectors++; if (mem_refresh !== 1'b1 || mem_rd !== 1'b0) begin miscompares++; $display("FAIL refresh_slot got ref=%b rd=%b want 1/0", mem_refresh, mem_rd); end
        vectors++; if (slot_owner !== 2'd3) begin miscompares++; $display("FAIL refresh_owner got %0d want 3", slot_owner); end
        step();
        vectors++; if (mem_refresh !== 1'b0) begin miscompares++; $display("FAIL refresh_width got %b want 0", mem_refresh); end
        step(); step();
        vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL refresh_no_ack got %b want 0", cpu_ack); end
        step();
        vectors++; if (mem_rd !== 1'b1 || mem_addr !== 17'h00123 || slot_owner !== 2'd2) begin miscompares++; $display("FAIL post_refresh_cpu got rd=%b addr=%h owner=%0d want 1/00123/2", mem_rd, mem_addr, slot_owner); end
        vectors++; if (mem_refresh !== 1'b0) begin miscompares++; $display("FAIL refresh_single got %b want 0", mem_refresh); end
        cpu_req = 1'b0;
        step(); step();
        vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL cpu_ack_early got %b want 0", cpu_ack); end
        step();
        vectors++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h5A00_0123) begin miscompares++; $display("FAIL refresh_cpu_ack got ack=%b rdata=%h want 1/5a000123", cpu_ack, cpu_rdata); end
        step();
        vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL cpu_ack_pulse got %b want 0", cpu_ack); end
    endtask

    task automatic test_write_read();
        cx = 10'd0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h1F000; cpu_wdata = 32'hDEADBEEF; cpu_be = 4'hF;
        step();
        vectors++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin miscompares++; $display("FAIL wr_cmd got wr=%b rd=%b want 1/0", mem_wr, mem_rd); end
        vectors++; if (mem_addr !== 17'h1F000 || mem_wdata !== 32'hDEADBEEF || mem_be !== 4'hF) begin miscompares++; $display("FAIL wr_bus got %h/%h/%h want 1f000/deadbeef/f", mem_addr, mem_wdata, mem_be); end
        cpu_req = 1'b0;
        step(); step(); step();
        vectors++; if (cpu_ack !== 1'b1) begin miscompares++; $display("FAIL wr_ack got %b want 1", cpu_ack); end
        vectors++; if (cpu_rdata !== 32'h5A00_0123) begin miscompares++; $display("FAIL wr_rdata_kept got %h want 5a000123", cpu_rdata); end
        vectors++; if (mem_addr !== 17'h1F000) begin miscompares++; $display("FAIL wr_addr_hold got %h want 1f000", mem_addr); end
        cpu_req = 1'b1; cpu_we = 1'b0;
        step();
        vectors++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 17'h1F000) begin miscompares++; $display("FAIL rd_cmd got rd=%b wr=%b addr=%h want 1/0/1f000", mem_rd, mem_wr, mem_addr); end
        cpu_req = 1'b0;
        step(); step(); step();
        vectors++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_back got ack=%b rdata=%h want 1/deadbeef", cpu_ack, cpu_rdata); end
    endtask

    task automatic test_cmd_be();
        cx = 10'd0;
        cmd_req = 1'b1; cmd_we = 1'b1; cmd_addr = 17'h00042; cmd_wdata = 32'h11223344; cmd_be = 4'b0101;
        step();
        vectors++; if (slot_owner !== 2'd3 || mem_wr !== 1'b1 || mem_be !== 4'b0101) begin miscompares++; $display("FAIL cmd_wr got owner=%0d wr=%b be=%b want 3/1/0101", slot_owner, mem_wr, mem_be); end
        cmd_req = 1'b0;
        step(); step(); step();
        vectors++; if (cmd_ack !== 1'b1 || cpu_ack !== 1'b0) begin miscompares++; $display("FAIL cmd_wr_ack got cmd=%b cpu=%b want 1/0", cmd_ack, cpu_ack); end
        cmd_req = 1'b1; cmd_we = 1'b0;
        step();
        vectors++; if (mem_rd !== 1'b1 || mem_addr !== 17'h00042) begin miscompares++; $display("FAIL cmd_rd got rd=%b addr=%h want 1/00042", mem_rd, mem_addr); end
        cmd_req = 1'b0;
        step(); step(); step();
        vectors++; if (cmd_ack !== 1'b1 || cmd_rdata !== 32'h5A22_0044) begin miscompares++; $display("FAIL cmd_rd_back got ack=%b rdata=%h want 1/5a220044", cmd_ack, cmd_rdata); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_own [6];
`ifdef VDP_SUPER_ARB_FAIRNESS_EN
        exp_own[0] = 2'd2; exp_own[1] = 2'd2; exp_own[2] = 2'd3;
        exp_own[3] = 2'd2; exp_own[4] = 2'd2; exp_own[5] = 2'd3;
`else
        for (int i = 0; i < 6; i++) exp_own[i] = 2'd2;
`endif
        cx = 10'd0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00010;
        cmd_req = 1'b1; cmd_we = 1'b0; cmd_addr = 17'h00020;
        for (int s = 0; s < 6; s++) begin
            step();
            vectors++; if (slot_owner !== exp_own[s]) begin miscompares++; $display("FAIL fair_seq[%0d] got %0d want %0d", s, slot_owner, exp_own[s]); end
            step(); step(); step();
`ifndef VDP_SUPER_ARB_FAIRNESS_EN
            vectors++; if (cmd_ack !== 1'b0) begin miscompares++; $display("FAIL cmd_starve[%0d] got %b want 0", s, cmd_ack); end
`endif
        end
        cpu_req = 1'b0; cmd_req = 1'b0;
        step(); step(); step(); step();
    endtask

    task automatic test_reset_mid();
        cx = 10'd0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00077;
        step();
        reset_n = 1'b0;
        #1;
        vectors++; if (slot_owner !== 2'd0 || mem_rd !== 1'b0 || mem_addr !== 17'd0) begin miscompares++; $display("FAIL rst_mid_outs got owner=%0d rd=%b addr=%h want 0/0/0", slot_owner, mem_rd, mem_addr); end
        for (int k = 0; k < 5; k++) step();
        vectors++; if (cpu_ack !== 1'b0 || cpu_rdata !== 32'd0 || vrm_32 !== 32'd0) begin miscompares++; $display("FAIL rst_hold got ack=%b rdata=%h vrm=%h want 0", cpu_ack, cpu_rdata, vrm_32); end
        reset_n = 1'b1;
        step(); step();
        vectors++; if (cpu_ack !== 1'b0 || mem_rd !== 1'b0) begin miscompares++; $display("FAIL rst_no_ack got ack=%b rd=%b want 0/0", cpu_ack, mem_rd); end
        step();
        vectors++; if (mem_rd !== 1'b1 || mem_addr !== 17'h00077 || slot_owner !== 2'd2) begin miscompares++; $display("FAIL rst_regrant got rd=%b addr=%h owner=%0d want 1/00077/2", mem_rd, mem_addr, slot_owner); end
        cpu_req = 1'b0;
        step(); step(); step();
        vectors++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h5A00_0077) begin miscompares++; $display("FAIL rst_complete got ack=%b rdata=%h want 1/5a000077", cpu_ack, cpu_rdata); end
    endtask

    task automatic test_no_super();
        vdp_super = 1'b0; super_res_drawing = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00009;
        cx = 10'd2;
        step(); step();
        vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL nosuper_midslot got rd=%b want 0", mem_rd); end
        step();
        vectors++; if (slot_owner !== 2'd2 || mem_rd !== 1'b1 || mem_addr !== 17'h00009) begin miscompares++; $display("FAIL nosuper_cpu got owner=%0d rd=%b addr=%h want 2/1/00009", slot_owner, mem_rd, mem_addr); end
        cpu_req = 1'b0;
        step(); step(); step();
        vectors++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h5A00_0009) begin miscompares++; $display("FAIL nosuper_ack got ack=%b rdata=%h want 1/5a000009", cpu_ack, cpu_rdata); end
        vectors++; if (vrm_32 !== 32'd0) begin miscompares++; $display("FAIL nosuper_vrm got %h want 0", vrm_32); end
    endtask

    initial begin
        reset_n = 1'b0; cx = 10'd0;
        vdp_super = 1'b0; super_res_drawing = 1'b0; super_res_vram_addr = 17'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 17'd0; cpu_wdata = 32'd0; cpu_be = 4'd0;
        cmd_req = 1'b0; cmd_we = 1'b0; cmd_addr = 17'd0; cmd_wdata = 32'd0; cmd_be = 4'd0;
        step(); step(); step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_display();
        test_refresh();
        test_write_read();
        test_cmd_be();
        test_fairness();
        test_reset_mid();
        test_no_super();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vdp_super_vram_arbiter.md
# vdp_super_vram_arbiter

Sequences the 32-bit VRAM word port in super-res/super-mid modes. Four requesters share it: the display fetch (address `super_res_vram_addr`, data consumed via `vrm_32`), DRAM refresh, the CPU port and the command engine. Access is granted in fixed 4-cycle slots aligned to `cx[1:0]`. The block sits between the super-res renderer and the VRAM controller.

## Interface
Parameters:
- `REFRESH_CX`, 723: `cx` value at which one refresh slot per line becomes pending.
- `FAIR_LIMIT`, 2: consecutive CPU grants allowed while the command engine waits (used only with fairness enabled).

Ports:
- `clk`  in  1  pixel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cx`  in  10  horizontal dot counter.
- `vdp_super`  in  1  super modes enabled.
- `super_res_drawing`  in  1  display fetch window.
- `super_res_vram_addr`  in  17  display word address.
- `vrm_32`  out  32  display read data.
- `cpu_req`, `cpu_we`  in  1 each.
- `cpu_addr`  in  17.
- `cpu_wdata`  in  32.
- `cpu_be`  in  4.
- `cpu_ack`  out  1.
- `cpu_rdata`  out  32.
- `cmd_req`, `cmd_we`, `cmd_addr`, `cmd_wdata`, `cmd_be`, `cmd_ack`, `cmd_rdata`: same as the CPU set, for the command engine.
- `mem_addr`  out  17.
- `mem_wdata`  out  32.
- `mem_be`  out  4.
- `mem_rd`, `mem_wr`, `mem_refresh`  out  1 each.
- `mem_rdata`  in  32.
- `slot_owner`  out  2  0=idle, 1=display, 2=CPU, 3=command (3 also while refresh owns).

## Operation
- Slot phase is `cx[1:0]`.
- Arbitration happens only at phase 0. The winner owns phases 0–3.
- Priority at phase 0:
  1. Display, if `vdp_super && super_res_drawing`.
  2. Refresh, if pending.
  3. CPU, if `cpu_req`.
  4. Command, if `cmd_req`.
  5. Otherwise idle.
- Refresh pending flag: set when `cx==REFRESH_CX`; cleared when a refresh slot is granted.
  - If set and clear coincide, set wins.
  - The flag is not counted; at most one refresh is pending.
- Display slot:
  - Phase 0: `mem_rd=1`, `mem_addr=super_res_vram_addr`.
  - Phase 2: `vrm_32<=mem_rdata`.
- Refresh slot: `mem_refresh=1` for phase 0 only. `slot_owner=3`; no ack is issued.
- CPU/command slot:
  - Phase 0: latch `addr`, `we`, `wdata`, `be`, and drive `mem_rd` or `mem_wr` for 1 cycle with `mem_be`.
  - Phase 2: for reads, capture `mem_rdata` into `*_rdata`.
  - Phase 3: 1-cycle `*_ack`.
  - For writes, `*_rdata` is unchanged.
- Requesters hold `req` and payload until ack and drop `req` the cycle after ack. The arbiter re-grants only at the next phase 0, so back-to-back transactions from one requester are 4 cycles apart.
- If `req` drops after the grant, the transaction still completes and ack still pulses.
- `vdp_super=0`: no display slots; refresh, CPU and command proceed unchanged.
- `super_res_drawing` changing mid-slot does not affect the current slot.

## Timing
- Reset values: all outputs 0, refresh flag 0, fairness counter 0, `slot_owner=0`.
- Reset mid-slot aborts the slot with no ack. A held `req` is re-granted at the first phase 0 after reset release.
- `mem_*` command outputs are registered and are 1 cycle wide at phase 0.
- `mem_addr`, `mem_wdata` and `mem_be` are held through phase 3.
- Read latency: `mem_rdata` is valid at phase 2 (fixed 2 cycles after command).
- Ack latency: 3 cycles after the grant phase.
- `vrm_32` is stable from phase 3 of slot N through phase 2 of slot N+1.
- `mem_addr` arithmetic is 17-bit, with no wrap handling; the address passes through.

## Configuration
- `VDP_SUPER_ARB_FAIRNESS_EN` defined:
  - A 2-bit counter increments on each CPU grant made while `cmd_req` is high.
  - When the counter is ≥`FAIR_LIMIT` and `cmd_req` is high, the command engine beats the CPU; the counter clears on the command grant.
  - The counter also clears on any CPU grant with `cmd_req` low.
- Undefined: strict CPU > command. The command engine may starve.

## Test plan
- Display only, `super_res_drawing=1`, addresses 0,1,2: `mem_rd` at every `cx[1:0]==0`. `vrm_32` equals the model word for the address 3 cycles later; `cpu_req` held meanwhile gets no ack.
- `cx` passes 723 with drawing low and `cpu_req=1`: the next phase 0 gives `mem_refresh=1`; CPU is granted in the following slot with ack 7 cycles after slot start.
- CPU write `addr=0x1F000`, `wdata=0xDEADBEEF`, `be=0xF`, then read the same address: `mem_wr` then `mem_rd`; `cpu_rdata=0xDEADBEEF` at ack.
- Both requesters held continuously with fairness enabled: grant sequence CPU, CPU, CMD, CPU, CPU, CMD. With the macro off: CPU only, `cmd_ack` never pulses.
- `reset_n` low at phase 1 of a CPU read, released 5 cycles later: no `cpu_ack`, all outputs 0 during reset. The held request completes in the first slot after release.
- `vdp_super=0` with `super_res_drawing=1`: no display slots; a CPU request is granted at the next phase 0.
